i2s_transmitter: RTL and testbench

- Downstream output stage for the anti-noise path. It accepts signed 16-bit left/right samples from the FIR filter output with a one-cycle ready pulse.
- It double-buffers each sample pair and serialises it as a standard I2S stream (BCLK, LRCLK, SDATA) to an external I2S DAC/amplifier.
- It replaces the PWM audio path. Clock generation runs off the 100 MHz system clock.

---
 rtl/i2s_transmitter.sv | 248 ++++++++++++++++++++++++
 tb/tb_i2s_transmitter.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_transmitter.sv
// ---------------------------------------------------------------------------
// i2s_transmitter
//
// Output stage of the anti-noise path. Takes signed left/right samples from
// the FIR filter (one-cycle ready pulse), double-buffers them and serialises
// each pair as a standard I2S frame (BCLK, LRCLK, SDATA, MSB first, one-BCLK
// data delay after every LRCLK change) towards an external I2S DAC/amp.
//
// Timing is derived from the system clock: BCLK toggles every BCLK_HALF
// clk_in cycles, one frame is 2*SLOT_BITS BCLK periods. All serial outputs
// change together on the clk_in cycle in which BCLK falls, so the receiver
// always sees stable data on the BCLK rising edge.
//
// Buffering:
//   pending  <- written by every ready_in pulse (newest pair wins)
//   active   <- loaded from pending at each frame boundary; if nothing new
//               was pending the previous pair is simply repeated
//
// Requirements on the parameters:
//   SLOT_BITS is a power of two, SAMPLE_BITS <= SLOT_BITS-1, BCLK_HALF >= 2.
// ---------------------------------------------------------------------------
module i2s_transmitter #(
    parameter int BCLK_HALF   = 12,
    parameter int SLOT_BITS   = 32,
    parameter int SAMPLE_BITS = 16
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic                   ready_in,
    input  logic [SAMPLE_BITS-1:0] left_in,
    input  logic [SAMPLE_BITS-1:0] right_in,
    input  logic                   mute_in,
    output logic                   i2s_bclk_out,
    output logic                   i2s_lrclk_out,
    output logic                   i2s_data_out,
    output logic                   frame_start_out,
    output logic                   overrun_out
);

    // -----------------------------------------------------------------------
    // Derived sizes
    // -----------------------------------------------------------------------
    localparam int FRAME_BITS = 2 * SLOT_BITS;
    localparam int DIV_W      = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;
    localparam int CNT_W      = $clog2(FRAME_BITS);
    localparam int POS_W      = $clog2(SLOT_BITS);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_HALF - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_BITS - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [DIV_W-1:0] DIV_ZERO = {DIV_W{1'b0}};

    // -----------------------------------------------------------------------
    // Bit selection helper
    //
    // Returns the serial bit for slot position pos of one channel word:
    //   pos 0                  -> 0 (I2S one-BCLK delay)
    //   pos 1 .. SAMPLE_BITS   -> word[SAMPLE_BITS-pos] (MSB first)
    //   above SAMPLE_BITS      -> 0 (slot padding)
    // The slot is laid out MSB-first in a SLOT_BITS vector and then bit
    // reversed so the slot position can index it directly.
    // -----------------------------------------------------------------------
    function automatic logic slot_bit(
        input logic [SAMPLE_BITS-1:0] word,
        input logic [POS_W-1:0]       pos
    );
        logic [SLOT_BITS-1:0] msb_first;
        logic [SLOT_BITS-1:0] by_pos;
        msb_first = SLOT_BITS'({1'b0, word}) << (SLOT_BITS - 1 - SAMPLE_BITS);
        by_pos    = {<<{msb_first}};
        return by_pos[pos];
    endfunction

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [DIV_W-1:0]       div_cnt_r;
    logic                   bclk_r;
    logic [CNT_W-1:0]       bit_cnt_r;
    logic                   lrclk_r;
    logic                   data_r;
    logic                   frame_start_r;
    logic                   overrun_r;

    logic [SAMPLE_BITS-1:0] pend_left_r;
    logic [SAMPLE_BITS-1:0] pend_right_r;
    logic                   pend_valid_r;
    logic [SAMPLE_BITS-1:0] act_left_r;
    logic [SAMPLE_BITS-1:0] act_right_r;

    // -----------------------------------------------------------------------
    // Combinational decode
    // -----------------------------------------------------------------------
    logic                   div_wrap_s;
    logic                   fall_s;
    logic                   load_s;
    logic [CNT_W-1:0]       bit_cnt_next_s;
    logic                   slot_s;
    logic [POS_W-1:0]       pos_s;
    logic                   data_next_s;
    logic                   overrun_s;

    // Decode divider wrap, BCLK falling event, frame boundary and next bit.
    always_comb begin
        div_wrap_s     = 1'b0;
        fall_s         = 1'b0;
        load_s         = 1'b0;
        bit_cnt_next_s = CNT_ZERO;
        slot_s         = 1'b0;
        pos_s          = {POS_W{1'b0}};
        data_next_s    = 1'b0;
        overrun_s      = 1'b0;

        div_wrap_s = (div_cnt_r == DIV_LAST);

        // A wrap while BCLK is high means BCLK is about to fall.
        fall_s = div_wrap_s & bclk_r;

        // Frame boundary: the falling edge that takes bit_cnt 63 -> 0.
        load_s = fall_s & (bit_cnt_r == CNT_LAST);

        if (bit_cnt_r == CNT_LAST) begin
            bit_cnt_next_s = CNT_ZERO;
        end else begin
            bit_cnt_next_s = bit_cnt_r + CNT_W'(1);
        end

        slot_s = bit_cnt_next_s[CNT_W-1];
        pos_s  = bit_cnt_next_s[POS_W-1:0];

        // On the load cycle pos_s is 0, so the not-yet-updated active word
        // is never observed on the line.
        if (slot_s) begin
            data_next_s = slot_bit(act_right_r, pos_s);
        end else begin
            data_next_s = slot_bit(act_left_r, pos_s);
        end

        // A pending pair that never reached the active registers is being
        // replaced. On the load cycle the old pair moves to active first,
        // so nothing is lost there.
        if (ready_in && pend_valid_r && !load_s) begin
            overrun_s = 1'b1;
        end else begin
            overrun_s = 1'b0;
        end
    end

    // -----------------------------------------------------------------------
    // Sequential logic
    // -----------------------------------------------------------------------

    // BCLK divider: toggle BCLK every BCLK_HALF system clocks.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            div_cnt_r <= DIV_ZERO;
            bclk_r    <= 1'b0;
        end else if (div_wrap_s) begin
            div_cnt_r <= DIV_ZERO;
            bclk_r    <= ~bclk_r;
        end else begin
            div_cnt_r <= div_cnt_r + DIV_W'(1);
        end
    end

    // Frame bit counter, word select and serial data, all moving on BCLK fall.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            bit_cnt_r <= CNT_ZERO;
            lrclk_r   <= 1'b0;
            data_r    <= 1'b0;
        end else if (fall_s) begin
            bit_cnt_r <= bit_cnt_next_s;
            lrclk_r   <= slot_s;
            data_r    <= data_next_s;
        end else begin
            bit_cnt_r <= bit_cnt_r;
            lrclk_r   <= lrclk_r;
            data_r    <= data_r;
        end
    end

    // Active sample pair: refreshed from pending (or muted) at each frame start.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            act_left_r  <= '0;
            act_right_r <= '0;
        end else if (load_s) begin
            if (mute_in) begin
                act_left_r  <= '0;
                act_right_r <= '0;
            end else if (pend_valid_r) begin
                act_left_r  <= pend_left_r;
                act_right_r <= pend_right_r;
            end else begin
                act_left_r  <= act_left_r;
                act_right_r <= act_right_r;
            end
        end else begin
            act_left_r  <= act_left_r;
            act_right_r <= act_right_r;
        end
    end

    // Pending sample pair: captured on ready_in, consumed at frame start.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            pend_left_r  <= '0;
            pend_right_r <= '0;
            pend_valid_r <= 1'b0;
        end else if (ready_in) begin
            // Also covers ready_in on the load cycle: the load above used
            // the old contents, the new pair is left waiting.
            pend_left_r  <= left_in;
            pend_right_r <= right_in;
            pend_valid_r <= 1'b1;
        end else if (load_s) begin
            pend_left_r  <= pend_left_r;
            pend_right_r <= pend_right_r;
            pend_valid_r <= 1'b0;
        end else begin
            pend_left_r  <= pend_left_r;
            pend_right_r <= pend_right_r;
            pend_valid_r <= pend_valid_r;
        end
    end

    // Status pulses, registered so they line up with the serial outputs.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            frame_start_r <= 1'b0;
            overrun_r     <= 1'b0;
        end else begin
            frame_start_r <= load_s;
            overrun_r     <= overrun_s;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs (all straight from registers)
    // -----------------------------------------------------------------------
    assign i2s_bclk_out    = bclk_r;
    assign i2s_lrclk_out   = lrclk_r;
    assign i2s_data_out    = data_r;
    assign frame_start_out = frame_start_r;
    assign overrun_out     = overrun_r;

endmodule

// File: tb/tb_i2s_transmitter.sv
// ---------------------------------------------------------------------------
// Self-checking bench for i2s_transmitter.
// The reference model works on the timeline since reset release: BCLK edge
// times, frame boundaries and slot positions are computed arithmetically from
// the cycle count, and a small pending/active pair model tracks which sample
// pair each frame should carry.
// ---------------------------------------------------------------------------
module tb_i2s_transmitter;

    localparam int HALF  = 12;
    localparam int BCLK  = 2 * HALF;
    localparam int FRAME = 64 * BCLK;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        ready_in;
    logic [15:0] left_in;
    logic [15:0] right_in;
    logic        mute_in;
    logic        i2s_bclk_out;
    logic        i2s_lrclk_out;
    logic        i2s_data_out;
    logic        frame_start_out;
    logic        overrun_out;

    i2s_transmitter dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .ready_in        (ready_in),
        .left_in         (left_in),
        .right_in        (right_in),
        .mute_in         (mute_in),
        .i2s_bclk_out    (i2s_bclk_out),
        .i2s_lrclk_out   (i2s_lrclk_out),
        .i2s_data_out    (i2s_data_out),
        .frame_start_out (frame_start_out),
        .overrun_out     (overrun_out)
    );

    always #5 clk_in = ~clk_in;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    logic [15:0] m_pend_l, m_pend_r, m_act_l, m_act_r;
    logic        m_pend_v;
    logic [63:0] rx_bits  = 64'h0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t (cyc %0d): got %h expected %h", tag, $time, cyc, act, exp);
        end
    endtask

    function automatic logic [63:0] frame_of(input logic [15:0] l, input logic [15:0] r);
        return {1'b0, l, 15'h0, 1'b0, r, 15'h0};
    endfunction

    // Expected serial bit for the BCLK period that covers cycle c.
    function automatic logic exp_data_at(input int c);
        int          idx;
        int          p;
        logic [15:0] w;
        logic [3:0]  bi;
        idx = (c / BCLK) % 64;
        p   = idx % 32;
        w   = (idx >= 32) ? m_act_r : m_act_l;
        if (p >= 1 && p <= 16) begin
            bi = 4'(16 - p);
            return w[bi];
        end
        return 1'b0;
    endfunction

    task automatic model_reset();
        cyc      = 0;
        m_pend_l = 16'h0;
        m_pend_r = 16'h0;
        m_act_l  = 16'h0;
        m_act_r  = 16'h0;
        m_pend_v = 1'b0;
    endtask

    // One clock: update the model with the inputs seen at this edge, then check.
    task automatic step();
        logic load;
        logic exp_fs;
        logic exp_ov;
        int   idx;
        @(posedge clk_in);
        cyc++;
        load   = (cyc % FRAME == 0);
        exp_fs = load;
        exp_ov = ready_in && m_pend_v && !load;
        if (load) begin
            if (mute_in) begin
                m_act_l = 16'h0;
                m_act_r = 16'h0;
            end else if (m_pend_v) begin
                m_act_l = m_pend_l;
                m_act_r = m_pend_r;
            end
            m_pend_v = 1'b0;
        end
        if (ready_in) begin
            m_pend_l = left_in;
            m_pend_r = right_in;
            m_pend_v = 1'b1;
        end
        #1;
        check("frame_start", 64'(frame_start_out), 64'(exp_fs));
        check("overrun", 64'(overrun_out), 64'(exp_ov));
        if (cyc % HALF == 0 || cyc % HALF == HALF - 1) begin
            check("bclk", 64'(i2s_bclk_out), 64'((cyc / HALF) % 2));
        end
        if (cyc % BCLK == HALF) begin
            idx = (cyc / BCLK) % 64;
            check("lrclk", 64'(i2s_lrclk_out), 64'(idx / 32));
            check("data", 64'(i2s_data_out), 64'(exp_data_at(cyc)));
            rx_bits[63 - idx] = i2s_data_out;
        end
    endtask

    task automatic run_to_load();
        for (int i = 0; i < FRAME; i++) begin
            step();
            if (cyc % FRAME == 0) break;
        end
    endtask

    task automatic run_pre_load();
        for (int i = 0; i < FRAME; i++) begin
            if ((cyc + 1) % FRAME == 0) break;
            step();
        end
    endtask

    task automatic capture_frame();
        repeat (FRAME) step();
    endtask

    task automatic pulse(input logic [15:0] l, input logic [15:0] r);
        ready_in = 1'b1;
        left_in  = l;
        right_in = r;
        step();
        ready_in = 1'b0;
    endtask

    initial begin
        rst_in   = 1'b1;
        ready_in = 1'b0;
        mute_in  = 1'b0;
        left_in  = 16'h0;
        right_in = 16'h0;
        model_reset();

        // Reset state
        repeat (3) @(posedge clk_in);
        #1;
        check("rst_bclk", 64'(i2s_bclk_out), 64'h0);
        check("rst_lrclk", 64'(i2s_lrclk_out), 64'h0);
        check("rst_data", 64'(i2s_data_out), 64'h0);
        check("rst_fs", 64'(frame_start_out), 64'h0);
        check("rst_ov", 64'(overrun_out), 64'h0);
        @(negedge clk_in);
        rst_in = 1'b0;
        model_reset();

        // Idle: no input, silent frames with regular framing
        run_to_load();
        capture_frame();
        check("idle_frame", rx_bits, 64'h0);

        // Asymmetric pair: 8001 / 7FFE
        repeat (50) step();
        pulse(16'h8001, 16'h7FFE);
        run_to_load();
        capture_frame();
        check("pair_8001", rx_bits, frame_of(16'h8001, 16'h7FFE));

        // Repeat of last pair for three frames without new input
        repeat (100) step();
        pulse(16'h1234, 16'h1234);
        run_to_load();
        for (int f = 0; f < 3; f++) begin
            capture_frame();
            check("repeat_1234", rx_bits, frame_of(16'h1234, 16'h1234));
        end

        // Overrun: two pairs inside one frame, newer wins
        repeat (100) step();
        pulse(16'h0001, 16'h1111);
        repeat (200) step();
        pulse(16'h0002, 16'h2222);
        check("overrun_pulse", 64'(overrun_out), 64'h1);
        run_to_load();
        capture_frame();
        check("overrun_newer", rx_bits, frame_of(16'h0002, 16'h2222));

        // ready_in coincident with the load cycle
        repeat (100) step();
        pulse(16'h00AA, 16'h0A0A);
        run_pre_load();
        pulse(16'h00BB, 16'h0B0B);
        check("coinc_fs", 64'(frame_start_out), 64'h1);
        check("coinc_no_ov", 64'(overrun_out), 64'h0);
        capture_frame();
        check("coinc_old", rx_bits, frame_of(16'h00AA, 16'h0A0A));
        capture_frame();
        check("coinc_new", rx_bits, frame_of(16'h00BB, 16'h0B0B));

        // Mute at frame start, then async reset in the middle of the right slot
        repeat (100) step();
        pulse(16'h7FFF, 16'h7FFF);
        run_pre_load();
        mute_in = 1'b1;
        step();
        mute_in = 1'b0;
        while (cyc % FRAME != 40 * BCLK + 17) step();
        check("mute_left_zero", {32'h0, rx_bits[63:32]}, 64'h0);
        check("pre_rst_bclk", 64'(i2s_bclk_out), 64'h1);
        check("pre_rst_lrclk", 64'(i2s_lrclk_out), 64'h1);
        #3;
        rst_in = 1'b1;
        #1;
        check("arst_bclk", 64'(i2s_bclk_out), 64'h0);
        check("arst_lrclk", 64'(i2s_lrclk_out), 64'h0);
        check("arst_data", 64'(i2s_data_out), 64'h0);
        check("arst_fs", 64'(frame_start_out), 64'h0);
        check("arst_ov", 64'(overrun_out), 64'h0);
        repeat (3) @(posedge clk_in);
        @(negedge clk_in);
        rst_in = 1'b0;
        model_reset();
        repeat (HALF - 1) step();
        check("post_rst_bclk_low", 64'(i2s_bclk_out), 64'h0);
        step();
        check("post_rst_bclk_rise", 64'(i2s_bclk_out), 64'h1);
        check("post_rst_lrclk", 64'(i2s_lrclk_out), 64'h0);

        // Randomized traffic: sporadic pairs, occasional mute toggling
        repeat (6 * FRAME) begin
            ready_in = ($urandom_range(0, 299) == 0);
            left_in  = 16'($urandom);
            right_in = 16'($urandom);
            if ($urandom_range(0, 999) == 0) mute_in = ~mute_in;
            step();
        end
        ready_in = 1'b0;
        mute_in  = 1'b0;
        repeat (10) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
